// File: rtl/rs_issue_scheduler_if.sv
// -----------------------------------------------------------------------------
// rs_issue_scheduler_if
// Bundles the dispatch, slot-status, issue and completion signals that connect
// the reservation-slot issue scheduler to the decoder, the slot array and the FU.
//
// Signals (directions from the scheduler's point of view, modport slave):
//   dispatchValid      in   decoder presents an instruction for allocation
//   dispatchStall      out  dispatchValid while no slot is free
//   slotWr             out  one-hot write strobe into the slot array
//   allocSlot          out  index of the slot being written
//   slotBusy           in   per-slot busy status
//   slotReady          in   per-slot operands-ready status
//   slotInstrRecieved  out  one-hot, one-cycle release pulse to the issued slot
//   issueValid         out  issueSlot's contents are presented to the FU
//   issueSlot          out  select for the FU operand mux
//   fuReady            in   FU accepts the presented instruction this cycle
//   freeCount          out  number of slots with slotBusy=0
//
// Handshake: the FU takes an instruction on a cycle where issueValid=1 and
// fuReady=1. While issueValid=1 and fuReady=0, issueSlot is held stable.
// Modport master is the environment side (decoder + slot array + FU).
// -----------------------------------------------------------------------------
interface rs_issue_scheduler_if #(
  parameter int NUM_SLOTS = 4,
  parameter int IDX_WIDTH = $clog2(NUM_SLOTS),
  parameter int CNT_WIDTH = $clog2(NUM_SLOTS + 1)
);
  logic                 dispatchValid;
  logic                 dispatchStall;
  logic [NUM_SLOTS-1:0] slotWr;
  logic [IDX_WIDTH-1:0] allocSlot;
  logic [NUM_SLOTS-1:0] slotBusy;
  logic [NUM_SLOTS-1:0] slotReady;
  logic [NUM_SLOTS-1:0] slotInstrRecieved;
  logic                 issueValid;
  logic [IDX_WIDTH-1:0] issueSlot;
  logic                 fuReady;
  logic [CNT_WIDTH-1:0] freeCount;

  modport slave (
    input  dispatchValid, slotBusy, slotReady, fuReady,
    output dispatchStall, slotWr, allocSlot, slotInstrRecieved,
           issueValid, issueSlot, freeCount
  );

  modport master (
    output dispatchValid, slotBusy, slotReady, fuReady,
    input  dispatchStall, slotWr, allocSlot, slotInstrRecieved,
           issueValid, issueSlot, freeCount
  );
endinterface

// File: rtl/rs_issue_scheduler.sv
// -----------------------------------------------------------------------------
// rs_issue_scheduler
// Controller for a bank of NUM_SLOTS reservation slots feeding one FU.
//   - Allocation: lowest-index free slot gets a one-hot write strobe.
//   - Issue: a 3-state FSM (IDLE/GRANT/RELEASE) picks one busy+ready slot,
//     holds it to the FU until accepted, then pulses that slot's release strobe.
//   - Arbitration: round-robin by default. When the macro RS_AGE_PRIORITY_EN
//     is defined, an age matrix selects the oldest candidate instead and the
//     round-robin pointer is not built.
//
// Ports:
//   clk         in   system clock, all state on the rising edge
//   reset       in   asynchronous, active-high reset
//   bus         slave modport of rs_issue_scheduler_if (dispatch/issue/status)
//   dbg_state   out  current issue FSM state (0=IDLE, 1=GRANT, 2=RELEASE)
//   dbg_rr_ptr  out  round-robin pointer (constant 0 in the age-priority build)
// -----------------------------------------------------------------------------
module rs_issue_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int IDX_WIDTH = $clog2(NUM_SLOTS),
  parameter int CNT_WIDTH = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  rs_issue_scheduler_if.slave  bus,
  output logic [1:0]           dbg_state,
  output logic [IDX_WIDTH-1:0] dbg_rr_ptr
);

  localparam int IW1 = IDX_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;

  logic [NUM_SLOTS-1:0] free;
  logic [NUM_SLOTS-1:0] slot_wr;
  logic [IDX_WIDTH-1:0] alloc_slot;
  logic                 alloc_found;
  logic [CNT_WIDTH-1:0] free_count;

  logic [NUM_SLOTS-1:0] cand;
  logic                 win_found;
  logic [IDX_WIDTH-1:0] win_idx;

  logic [IDX_WIDTH-1:0] issue_slot;
  logic                 issue_load;
  logic                 issue_valid;
  logic [NUM_SLOTS-1:0] instr_rcv;

  // ---------------------------------------------------------------------------
  // Allocation (purely combinational, follows slotBusy/dispatchValid always)
  // ---------------------------------------------------------------------------
  always_comb begin
    free        = ~bus.slotBusy;
    slot_wr     = '0;
    alloc_slot  = '0;
    alloc_found = 1'b0;
    free_count  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (free[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_slot  = IDX_WIDTH'(i);
        slot_wr[i]  = bus.dispatchValid;
      end
      free_count = free_count + CNT_WIDTH'(free[i]);
    end
  end

  // A slot being written this cycle holds stale status, so it is excluded.
  assign cand = bus.slotBusy & bus.slotReady & ~slot_wr;

`ifdef RS_AGE_PRIORITY_EN
  // ---------------------------------------------------------------------------
  // Oldest-first arbitration. older[i][j]=1 means slot i was written before j.
  // ---------------------------------------------------------------------------
  logic [NUM_SLOTS-1:0] older [NUM_SLOTS];
  logic                 blocked;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) older[i] <= '0;
    end else begin
      for (int j = 0; j < NUM_SLOTS; j++) begin
        if (slot_wr[j]) begin
          // Everything already resident is older than the new entry; the new
          // entry is older than nothing.
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (i != j) older[i][j] <= bus.slotBusy[i];
          end
          older[j] <= '0;
        end
      end
    end
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    blocked   = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      blocked = 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (cand[k] && older[k][i]) blocked = 1'b1;
      end
      if (cand[i] && !blocked && !win_found) begin
        win_found = 1'b1;
        win_idx   = IDX_WIDTH'(i);
      end
    end
  end

  assign dbg_rr_ptr = '0;
`else
  // ---------------------------------------------------------------------------
  // Round-robin arbitration: search rr_ptr, rr_ptr+1, ... wrapping at NUM_SLOTS.
  // ---------------------------------------------------------------------------
  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [IW1-1:0]       rr_sum;
  logic [IDX_WIDTH-1:0] rr_idx;
  logic [IW1-1:0]       rr_inc;
  logic                 rr_load;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_sum    = '0;
    rr_idx    = '0;
    for (int off = 0; off < NUM_SLOTS; off++) begin
      rr_sum = {1'b0, rr_ptr} + IW1'(off);
      if (rr_sum >= IW1'(NUM_SLOTS)) rr_sum = rr_sum - IW1'(NUM_SLOTS);
      rr_idx = rr_sum[IDX_WIDTH-1:0];
      if (cand[rr_idx] && !win_found) begin
        win_found = 1'b1;
        win_idx   = rr_idx;
      end
    end
  end

  // Pointer moves past the issued slot as the FSM enters RELEASE.
  assign rr_load = (state == GRANT) && bus.fuReady;

  always_comb begin
    rr_inc = {1'b0, issue_slot} + IW1'(1);
    if (rr_inc >= IW1'(NUM_SLOTS)) rr_inc = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr <= '0;
    else if (rr_load) rr_ptr <= rr_inc[IDX_WIDTH-1:0];
  end

  assign dbg_rr_ptr = rr_ptr;
`endif

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next  = state;
    issue_load  = 1'b0;
    issue_valid = 1'b0;
    instr_rcv   = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          issue_load = 1'b1;
          state_next = GRANT;
        end
      end
      GRANT: begin
        issue_valid = 1'b1;
        if (bus.fuReady) state_next = RELEASE;
      end
      RELEASE: begin
        // The slot clears busy on the next edge, so it cannot be re-picked.
        instr_rcv[issue_slot] = 1'b1;
        state_next            = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Winner is latched only when leaving IDLE; held through GRANT and RELEASE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) issue_slot <= '0;
    else if (issue_load) issue_slot <= win_idx;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.slotWr            = slot_wr;
  assign bus.allocSlot         = alloc_slot;
  assign bus.dispatchStall     = bus.dispatchValid & ~|free;
  assign bus.freeCount         = free_count;
  assign bus.issueValid        = issue_valid;
  assign bus.issueSlot         = issue_slot;
  assign bus.slotInstrRecieved = instr_rcv;
  assign dbg_state             = state;

endmodule
